// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the five-stage pipeline: operand bypass, stall generation, mul/div tracking.
// Optional stall-cycle counter built only when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
    parameter int NREAD      = 2,
    parameter int DATA_W     = 32,
    parameter int REG_W      = 5,
    parameter int MULDIV_LAT = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    jD,
    input  logic                    mdD,
    input  logic [NREAD*REG_W-1:0]  rD,
    input  logic [NREAD*DATA_W-1:0] vD,
    input  logic [NREAD*REG_W-1:0]  rE,
    input  logic [NREAD*DATA_W-1:0] vE,
    input  logic                    regWriteE,
    input  logic                    loadE,
    input  logic [REG_W-1:0]        rdE,
    input  logic                    md_startE,
    input  logic                    regWriteM,
    input  logic                    loadM,
    input  logic [REG_W-1:0]        rdM,
    input  logic [DATA_W-1:0]       aluoutM,
    input  logic                    regWriteW,
    input  logic [REG_W-1:0]        rdW,
    input  logic [DATA_W-1:0]       vW,
    output logic [NREAD*DATA_W-1:0] vHD,
    output logic [NREAD*DATA_W-1:0] vHE,
    output logic                    stallF,
    output logic                    stallD,
    output logic                    flushE,
    output logic                    md_busy,
    output logic                    md_done,
    output logic [31:0]             stall_cnt
);
    localparam int CW = $clog2(MULDIV_LAT + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MULDIV_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} md_state_e;

    md_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREAD-1:0] hit_e, hit_m;
    logic            lu, br_e, br_m, md, stall;

    for (genvar i = 0; i < NREAD; i++) begin : g_slot
        logic [REG_W-1:0] rd_s, re_s;
        assign rd_s = rD[i*REG_W +: REG_W];
        assign re_s = rE[i*REG_W +: REG_W];

        // M beats W; register 0 always reads as zero.
        assign vHE[i*DATA_W +: DATA_W] =
            (re_s == '0)                   ? '0      :
            (regWriteM && (rdM == re_s))   ? aluoutM :
            (regWriteW && (rdW == re_s))   ? vW      :
                                             vE[i*DATA_W +: DATA_W];

        // W needs no bypass into D: the regfile writes before it is read.
        assign vHD[i*DATA_W +: DATA_W] =
            (rd_s == '0)                          ? '0      :
            (regWriteM && !loadM && (rdM == rd_s)) ? aluoutM :
                                                    vD[i*DATA_W +: DATA_W];

        assign hit_e[i] = (rd_s != '0) && (rd_s == rdE);
        assign hit_m[i] = (rd_s != '0) && (rd_s == rdM);
    end

    assign lu    = loadE & regWriteE & (|hit_e);
    assign br_e  = jD & regWriteE & (|hit_e);
    assign br_m  = jD & loadM & regWriteM & (|hit_m);
    assign md    = mdD & (md_busy | md_startE);
    assign stall = ~reset & (lu | br_e | br_m | md);

    assign stallF = stall;
    assign stallD = stall;
    assign flushE = stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A start arriving while BUSY is ignored; the md stall keeps it from happening.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (md_startE) begin
                state_d = S_BUSY;
                cnt_d   = CNT_LOAD;
            end
            S_BUSY: begin
                if (cnt_q == '0) state_d = S_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_DONE: begin
                if (md_startE) begin
                    state_d = S_BUSY;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        md_busy = (state_q == S_BUSY);
        md_done = (state_q == S_DONE);
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    always_ff @(posedge clk) begin
        if (reset)      stall_cnt_q <= '0;
        else if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
